mc_fork_arbiter: RTL

MC_FORK_ARBITER -- requirements
Module: mc_fork_arbiter

---
 rtl/mc_fork_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mc_fork_arbiter.sv
// Multicast fork arbiter: every input head flit is copied to each output in its mask.
// Each output runs its own round-robin among the inputs. A flit pops once all of its copies are issued.
module mc_fork_arbiter #(
    parameter int NUM_IN   = 5,
    parameter int NUM_OUT  = 5,
    parameter int DATASIZE = 30
) (
    input  logic                         ma_clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATASIZE-1:0]   in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN*NUM_OUT-1:0]    in_mask,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic [NUM_OUT-1:0]           out_full,
    output logic [NUM_OUT*DATASIZE-1:0]  out_data,
    output logic [NUM_OUT-1:0]           out_valid
);

    localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVING = 1'b1
    } st_e;

    st_e                         state_q [NUM_IN];
    st_e                         state_d [NUM_IN];
    logic [NUM_OUT-1:0]          pend_q [NUM_IN];
    logic [NUM_OUT-1:0]          pend_d [NUM_IN];
    logic [PW-1:0]               ptr_q [NUM_OUT];
    logic [PW-1:0]               ptr_d [NUM_OUT];
    logic [NUM_OUT*DATASIZE-1:0] out_data_q;
    logic [NUM_OUT*DATASIZE-1:0] out_data_d;
    logic [NUM_OUT-1:0]          out_valid_q;
    logic [NUM_OUT-1:0]          out_valid_d;

    logic [NUM_OUT-1:0]          req_s [NUM_IN];
    logic [NUM_OUT-1:0]          granted_s [NUM_IN];
    logic [NUM_OUT-1:0]          rem_s [NUM_IN];
    logic [NUM_OUT-1:0]          gnt_any_s;
    logic [PW-1:0]               gnt_src_s [NUM_OUT];
    logic [NUM_IN-1:0]           in_ready_s;

    // Effective request per input; a serving input that loses valid stops requesting
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            req_s[i] = '0;
            if (in_valid[i]) begin
                if (state_q[i] == ST_SERVING) begin
                    req_s[i] = pend_q[i];
                end else begin
                    req_s[i] = in_mask[i*NUM_OUT +: NUM_OUT];
                end
            end else begin
                req_s[i] = '0;
            end
        end
    end

    // Per-output round-robin search starting at ptr, ascending with wrap
    always_comb begin
        int   idx;
        logic hit;
        idx       = 0;
        hit       = 1'b0;
        gnt_any_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            granted_s[i] = '0;
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            gnt_src_s[j] = '0;
            for (int off = 0; off < NUM_IN; off++) begin
                idx = (int'(ptr_q[j]) + off) % NUM_IN;
                hit = !out_full[j] && !gnt_any_s[j] && req_s[idx][j];
                if (hit) begin
                    gnt_any_s[j]      = 1'b1;
                    gnt_src_s[j]      = PW'(idx);
                    granted_s[idx][j] = 1'b1;
                end else begin
                    gnt_any_s[j] = gnt_any_s[j];
                end
            end
        end
    end

    // Pop when nothing remains; otherwise carry the leftover outputs into pend
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            rem_s[i]      = req_s[i] & ~granted_s[i];
            in_ready_s[i] = !rst && in_valid[i] && (rem_s[i] == '0);
            state_d[i]    = state_q[i];
            pend_d[i]     = pend_q[i];
            if (in_ready_s[i]) begin
                state_d[i] = ST_IDLE;
                pend_d[i]  = '0;
            end else if (in_valid[i] && (rem_s[i] != '0)) begin
                state_d[i] = ST_SERVING;
                pend_d[i]  = rem_s[i];
            end else begin
                state_d[i] = state_q[i];
                pend_d[i]  = pend_q[i];
            end
        end
    end

    // Output flit capture and pointer advance past the winner
    always_comb begin
        out_valid_d = '0;
        out_data_d  = out_data_q;
        for (int j = 0; j < NUM_OUT; j++) begin
            ptr_d[j] = ptr_q[j];
            if (gnt_any_s[j]) begin
                out_valid_d[j]                       = 1'b1;
                out_data_d[j*DATASIZE +: DATASIZE]   = in_data[int'(gnt_src_s[j])*DATASIZE +: DATASIZE];
                ptr_d[j] = (int'(gnt_src_s[j]) == NUM_IN - 1) ? '0 : gnt_src_s[j] + PW'(1'b1);
            end else begin
                ptr_d[j] = ptr_q[j];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge ma_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                state_q[i] <= ST_IDLE;
                pend_q[i]  <= '0;
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                ptr_q[j] <= '0;
            end
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                state_q[i] <= state_d[i];
                pend_q[i]  <= pend_d[i];
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                ptr_q[j] <= ptr_d[j];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
